serial_subtractor: RTL and testbench

- Bit-serial N-bit subtractor: computes diff = a − b one bit per clock, LSB first.
- Uses a single half/full-subtractor cell and a borrow flip-flop. It is the subtraction counterpart of the team's adder cells.
- Sits in the arithmetic datapath library as a low-area alternative to a parallel subtractor.
- Uses a start/busy/done handshake with results held until the next operation.

---
 rtl/serial_subtractor.sv | 64 ++++++
 tb/tb_serial_subtractor.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b, LSB first, one full-subtractor cell plus a borrow flop
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  logic [1:0]       state;
  logic [WIDTH-1:0] sa, sb, rr, rr_next;
  logic [WIDTH:0]   rr_ext;
  logic [CW-1:0]    cnt;
  logic             br, d, br_next;
  always_comb begin
    d = sa[0] ^ sb[0] ^ br;
    br_next = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
    rr_ext = {d, rr};
    rr_next = rr_ext[WIDTH:1];
  end
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      sa <= '0;
      sb <= '0;
      rr <= '0;
      br <= 1'b0;
      cnt <= '0;
      diff <= '0;
      borrow_out <= 1'b0;
    end else
      case (state)
        IDLE: if (start) begin
          sa <= a;
          sb <= b;
          br <= 1'b0;
          cnt <= '0;
          state <= RUN;
        end
        RUN: begin
          sa <= sa >> 1;
          sb <= sb >> 1;
          rr <= rr_next;
          br <= br_next;
          cnt <= cnt + CW'(1);
          // last bit: publish the full result including the bit just computed
          if (cnt == CW'(WIDTH - 1)) begin
            diff <= rr_next;
            borrow_out <= br_next;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: random and directed checks of serial_subtractor at WIDTH 8, 16 and 1
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic rst;
  logic [31:0] a_bus, b_bus;
  logic s8, s16, s1;
  logic busy8, done8, bo8, busy16, done16, bo16, busy1, done1, bo1;
  logic [7:0] diff8;
  logic [15:0] diff16;
  logic [0:0] diff1;
  int n_assert = 0;
  int n_fail = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .start(s8), .a(a_bus[7:0]), .b(b_bus[7:0]),
    .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8));
  serial_subtractor #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .start(s16), .a(a_bus[15:0]), .b(b_bus[15:0]),
    .busy(busy16), .done(done16), .diff(diff16), .borrow_out(bo16));
  serial_subtractor #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .start(s1), .a(a_bus[0:0]), .b(b_bus[0:0]),
    .busy(busy1), .done(done1), .diff(diff1), .borrow_out(bo1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic busy_of(input int w);
    return w == 8 ? busy8 : w == 16 ? busy16 : busy1;
  endfunction
  function automatic logic done_of(input int w);
    return w == 8 ? done8 : w == 16 ? done16 : done1;
  endfunction
  function automatic logic [31:0] diff_of(input int w);
    return w == 8 ? {24'd0, diff8} : w == 16 ? {16'd0, diff16} : {31'd0, diff1};
  endfunction
  function automatic logic bo_of(input int w);
    return w == 8 ? bo8 : w == 16 ? bo16 : bo1;
  endfunction
  task automatic set_start(input int w, input logic v);
    if (w == 8) s8 = v; else if (w == 16) s16 = v; else s1 = v;
  endtask

  task automatic op(input int w, input logic [31:0] av, input logic [31:0] bv, input string tag);
    longint mask, ea, eb;
    logic [31:0] exp_d;
    logic exp_b;
    int n;
    mask = (longint'(1) << w) - 1;
    ea = longint'(av) & mask;
    eb = longint'(bv) & mask;
    exp_d = 32'((ea - eb) & mask);
    exp_b = ea < eb;
    @(negedge clk);
    a_bus = av;
    b_bus = bv;
    set_start(w, 1'b1);
    @(negedge clk);
    set_start(w, 1'b0);
    a_bus = $urandom;
    b_bus = $urandom;
    chk({tag, "_busy_rise"}, {31'd0, busy_of(w)}, 32'd1);
    chk({tag, "_done_early"}, {31'd0, done_of(w)}, 32'd0);
    n = 0;
    while (!done_of(w) && n < w + 4) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, n, w);
    chk({tag, "_diff"}, diff_of(w), exp_d);
    chk({tag, "_borrow"}, {31'd0, bo_of(w)}, {31'd0, exp_b});
    @(negedge clk);
    chk({tag, "_done_width"}, {31'd0, done_of(w)}, 32'd0);
    chk({tag, "_busy_fall"}, {31'd0, busy_of(w)}, 32'd0);
    chk({tag, "_diff_hold"}, diff_of(w), exp_d);
  endtask

  initial begin
    logic [16:0] q[$];
    logic [16:0] e;
    int last_done, dcount;
    rst = 1'b1;
    s8 = 1'b0;
    s16 = 1'b0;
    s1 = 1'b0;
    a_bus = '0;
    b_bus = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy8}, 32'd0);
    chk("rst_done", {31'd0, done8}, 32'd0);
    chk("rst_diff", {24'd0, diff8}, 32'd0);
    chk("rst_borrow", {31'd0, bo8}, 32'd0);
    rst = 1'b0;

    op(8, 32'd5, 32'd3, "d5m3");
    chk("d5m3_const", {23'd0, bo8, diff8}, 32'h002);
    op(8, 32'd3, 32'd5, "d3m5");
    chk("d3m5_const", {23'd0, bo8, diff8}, 32'h1FE);
    op(8, 32'h00, 32'hFF, "d00mFF");
    op(8, 32'hFF, 32'h00, "dFFm00");
    for (int i = 0; i < 4; i++) begin
      op(1, 32'(i >> 1), 32'(i & 1), "w1");
      chk("w1_truth", {30'd0, bo1, diff1}, (i == 1) ? 32'd3 : (i == 2) ? 32'd1 : 32'd0);
    end

    last_done = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done8) begin
        if (q.size() == 0) chk("hold_unexpected_done", 32'd1, 32'd0);
        else begin
          e = q.pop_front();
          chk("hold_result", {23'd0, bo8, diff8},
              {23'd0, ({1'b0, e[15:8]} - {1'b0, e[7:0]})});
        end
        if (last_done >= 0) chk("hold_spacing", cyc - last_done, 32'd10);
        last_done = cyc;
      end
      s8 = i < 40;
      a_bus = $urandom;
      b_bus = $urandom;
      if (i < 40 && !busy8) q.push_back({1'b0, a_bus[7:0], b_bus[7:0]});
    end
    chk("hold_drained", q.size(), 32'd0);
    s8 = 1'b0;

    @(negedge clk);
    a_bus = 32'd5;
    b_bus = 32'd3;
    s8 = 1'b1;
    @(negedge clk);
    s8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy8}, 32'd0);
    chk("abort_done", {31'd0, done8}, 32'd0);
    chk("abort_diff", {24'd0, diff8}, 32'd0);
    chk("abort_borrow", {31'd0, bo8}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    dcount = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8) dcount++;
    end
    chk("abort_no_done", dcount, 32'd0);
    op(8, 32'd200, 32'd100, "post_rst");
    chk("post_rst_const", {23'd0, bo8, diff8}, 32'd100);

    for (int i = 0; i < 1000; i++) begin
      op(8, $urandom, $urandom, "rnd8");
      op(16, $urandom, $urandom, "rnd16");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
